// File: rtl/frame_gen_pkg.sv
// Shared definitions for the frame generator: scan FSM encoding, default
// frame geometry and the 2-bit pixel codes also used by pixel_memory.
package frame_gen_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DEF_FRAME_WIDTH  = 640;
    localparam int DEF_FRAME_HEIGHT = 480;

    localparam logic [1:0] PIX_BLACK = 2'b00;
    localparam logic [1:0] PIX_GREY  = 2'b01;
    localparam logic [1:0] PIX_WHITE = 2'b11;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Column/row raster counter with enable and clear, flagging the first pixel,
// the last column of a line and the last pixel of a frame.
module raster_counter
    import frame_gen_pkg::*;
#(
    parameter int WIDTH  = DEF_FRAME_WIDTH,
    parameter int HEIGHT = DEF_FRAME_HEIGHT,
    parameter int COL_W  = cnt_width(WIDTH),
    parameter int ROW_W  = cnt_width(HEIGHT)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             is_first_o,
    output logic             is_eol_o,
    output logic             is_eof_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             last_row_s;

    assign is_first_o = (col_q == {COL_W{1'b0}}) && (row_q == {ROW_W{1'b0}});
    assign is_eol_o   = (col_q == COL_W'(WIDTH - 1));
    assign last_row_s = (row_q == ROW_W'(HEIGHT - 1));
    assign is_eof_o   = is_eol_o && last_row_s;
    assign col_o      = col_q;
    assign row_o      = row_q;

    // Next position: column wraps into the next row, row wraps at frame end.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = {COL_W{1'b0}};
            row_d = {ROW_W{1'b0}};
        end else if (en_i) begin
            if (is_eol_o) begin
                col_d = {COL_W{1'b0}};
                if (last_row_s) begin
                    row_d = {ROW_W{1'b0}};
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= {COL_W{1'b0}};
            row_q <= {ROW_W{1'b0}};
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/frame_scan_controller.sv
// Raster-scan sequencer: walks pixel_memory in raster order and emits the
// pixels as a back-pressured stream with frame/line markers.
module frame_scan_controller
    import frame_gen_pkg::*;
#(
    parameter int frame_width  = DEF_FRAME_WIDTH,
    parameter int frame_height = DEF_FRAME_HEIGHT,
    parameter int FRAME_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [FRAME_CNT_W-1:0] num_frames,
    input  logic                   stop,
    output logic [31:0]            col_addr,
    output logic [31:0]            row_addr,
    input  logic [1:0]             pix_value,
    output logic [1:0]             m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_sof,
    output logic                   m_eol,
    output logic                   m_eof,
    output logic                   busy,
    output logic                   done,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int COL_W = cnt_width(frame_width);
    localparam int ROW_W = cnt_width(frame_height);

    logic [1:0]             state_q, state_d;
    logic [FRAME_CNT_W-1:0] num_frames_q, num_frames_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic                   stop_flag_q, stop_flag_d;
    logic [1:0]             m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_sof_q, m_sof_d;
    logic                   m_eol_q, m_eol_d;
    logic                   m_eof_q, m_eof_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   ld_s, cnt_en_s, cnt_clr_s;
    logic [COL_W-1:0]       col_s;
    logic [ROW_W-1:0]       row_s;
    logic                   is_first_s, is_eol_s, is_eof_s;

    assign ld_s      = !m_valid_q || m_ready;
    assign cnt_en_s  = (state_q == ST_SCAN) && ld_s;
    assign cnt_clr_s = (state_q != ST_SCAN);

    raster_counter #(
        .WIDTH  (frame_width),
        .HEIGHT (frame_height),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W)
    ) u_raster (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (cnt_clr_s),
        .en_i       (cnt_en_s),
        .col_o      (col_s),
        .row_o      (row_s),
        .is_first_o (is_first_s),
        .is_eol_o   (is_eol_s),
        .is_eof_o   (is_eof_s)
    );

    // Scan FSM, output beat register and frame accounting.
    always_comb begin
        state_d       = state_q;
        num_frames_d  = num_frames_q;
        frame_count_d = frame_count_q;
        stop_flag_d   = stop_flag_q;
        m_data_d      = m_data_q;
        m_valid_d     = m_valid_q;
        m_sof_d       = m_sof_q;
        m_eol_d       = m_eol_q;
        m_eof_d       = m_eof_q;
        case (state_q)
            ST_IDLE: begin
                m_valid_d = 1'b0;
                if (start) begin
                    state_d       = ST_SCAN;
                    num_frames_d  = num_frames;
                    frame_count_d = {FRAME_CNT_W{1'b0}};
                    stop_flag_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                stop_flag_d = stop_flag_q || stop;
                if (ld_s) begin
                    m_data_d  = pix_value;
                    m_valid_d = 1'b1;
                    m_sof_d   = is_first_s;
                    m_eol_d   = is_eol_s;
                    m_eof_d   = is_eof_s;
                    // A frame only ends on its last pixel, so stop never truncates.
                    if (is_eof_s) begin
                        frame_count_d = frame_count_q + FRAME_CNT_W'(1);
                        if (((num_frames_q != {FRAME_CNT_W{1'b0}}) &&
                             (frame_count_d == num_frames_q)) || stop_flag_d) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_SCAN;
                        end
                    end else begin
                        state_d = ST_SCAN;
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                stop_flag_d = stop_flag_q || stop;
                if (m_valid_q && m_ready) begin
                    state_d   = ST_DONE;
                    m_valid_d = 1'b0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_SCAN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            num_frames_q  <= {FRAME_CNT_W{1'b0}};
            frame_count_q <= {FRAME_CNT_W{1'b0}};
            stop_flag_q   <= 1'b0;
            m_data_q      <= 2'b00;
            m_valid_q     <= 1'b0;
            m_sof_q       <= 1'b0;
            m_eol_q       <= 1'b0;
            m_eof_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_frames_q  <= num_frames_d;
            frame_count_q <= frame_count_d;
            stop_flag_q   <= stop_flag_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            m_sof_q       <= m_sof_d;
            m_eol_q       <= m_eol_d;
            m_eof_q       <= m_eof_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign col_addr    = 32'(col_s);
    assign row_addr    = 32'(row_s);
    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_sof       = m_sof_q;
    assign m_eol       = m_eol_q;
    assign m_eof       = m_eof_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_scan_controller.sv
// Scoreboard bench for frame_scan_controller on a 4x3 frame: expected beats
// are queued from a raster-order model of the memory, a monitor pops and compares.
module tb_frame_scan_controller;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int NPX = W * H;

    typedef struct packed {
        logic [1:0] d;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    logic        clk, rst, start, stop, m_ready;
    logic [15:0] num_frames;
    logic [31:0] col_addr, row_addr;
    logic [1:0]  pix_value, m_data;
    logic        m_valid, m_sof, m_eol, m_eof, busy, done;
    logic [15:0] frame_count;

    logic [1:0]  mem [NPX];
    beat_t       exp_q [$];
    int          checks, errors, beat_cnt, ready_mode;
    bit          done_seen;

    frame_scan_controller #(.frame_width(W), .frame_height(H), .FRAME_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_frames(num_frames), .stop(stop),
        .col_addr(col_addr), .row_addr(row_addr), .pix_value(pix_value),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof),
        .busy(busy), .done(done), .frame_count(frame_count)
    );

    assign pix_value = (row_addr < 32'd3 && col_addr < 32'd4) ?
                       mem[row_addr * 4 + col_addr] : 2'b10;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: n whole frames in raster order.
    task automatic push_frames(input int n);
        beat_t b;
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < NPX; i++) begin
                b.d   = mem[i];
                b.sof = (i == 0);
                b.eol = ((i % W) == W - 1);
                b.eof = (i == NPX - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Downstream ready generator.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops expected beats on acceptance, checks stalls and done.
    initial begin
        beat_t b;
        bit    stall_prev, done_exp;
        logic [4:0]  snap_df;
        logic [31:0] snap_addr;
        stall_prev = 1'b0;
        done_exp   = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                stall_prev = 1'b0;
                done_exp   = 1'b0;
            end else begin
                if (done_exp || done) begin
                    checks++;
                    if (!(done_exp && done && !busy && !m_valid)) begin
                        errors++;
                        $display("FAIL done_pulse actual done=%0b busy=%0b valid=%0b expected done=%0b busy=0 valid=0",
                                 done, busy, m_valid, done_exp);
                    end
                    if (done) done_seen = 1'b1;
                    done_exp = 1'b0;
                end
                if (stall_prev) begin
                    chk("stall_data_flags", {27'd0, m_valid, m_data, m_sof, m_eol, m_eof},
                        {27'd0, 1'b1, snap_df});
                    chk("stall_addr", {col_addr[15:0], row_addr[15:0]}, snap_addr);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 32'd1, 32'd0);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat", {27'd0, m_data, m_sof, m_eol, m_eof},
                            {27'd0, b.d, b.sof, b.eol, b.eof});
                        beat_cnt++;
                        if (exp_q.size() == 0) done_exp = 1'b1;
                    end
                end
                stall_prev = m_valid && !m_ready;
                snap_df    = {m_data, m_sof, m_eol, m_eof};
                snap_addr  = {col_addr[15:0], row_addr[15:0]};
            end
        end
    end

    task automatic wait_beats(input int n);
        int k;
        k = 0;
        while (beat_cnt < n && k < 2000) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (beat_cnt < n) chk("wait_beats_timeout", beat_cnt, n);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done_seen && k < 3000) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
        chk("queue_drained", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic begin_scan(input logic [15:0] nf, input int frames_exp);
        beat_cnt  = 0;
        done_seen = 1'b0;
        @(negedge clk);
        push_frames(frames_exp);
        num_frames = nf;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        num_frames = 16'd0;
    endtask

    initial begin
        int pick;
        checks = 0; errors = 0; beat_cnt = 0; ready_mode = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; num_frames = 16'd0; done_seen = 1'b0;
        for (int i = 0; i < NPX; i++) begin
            pick   = int'($urandom_range(0, 2));
            mem[i] = (pick == 2) ? 2'b11 : 2'(pick);
        end
        mem[0] = 2'b11; mem[1] = 2'b01; mem[2] = 2'b00;
        repeat (3) @(negedge clk);
        #3;
        chk("reset_outputs", {col_addr[7:0], row_addr[7:0], m_data, m_valid, m_sof, m_eol, m_eof, busy, done},
            32'd0);
        chk("reset_frame_count", frame_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: single frame, full throughput, latency checks.
        ready_mode = 0;
        beat_cnt = 0; done_seen = 1'b0;
        @(negedge clk);
        push_frames(1);
        num_frames = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #3;
        chk("latency_busy_n1", {busy, m_valid}, 32'b10);
        @(negedge clk);
        #3;
        chk("latency_first_beat_n2", {m_valid, m_sof, m_data}, {29'd0, 1'b1, 1'b1, mem[0]});
        chk("addr_advanced", col_addr, 32'd1);
        wait_done();
        chk("fc_single", frame_count, 32'd1);

        // 2: same scan under random back-pressure.
        ready_mode = 1;
        begin_scan(16'd1, 1);
        wait_done();
        chk("fc_random_ready", frame_count, 32'd1);

        // 3: continuous with stop partway through frame 2.
        ready_mode = 0;
        begin_scan(16'd0, 2);
        wait_beats(14);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done();
        chk("fc_stop", frame_count, 32'd2);

        // 4: three frames, start re-pulsed mid-scan must be ignored.
        ready_mode = 1;
        begin_scan(16'd3, 3);
        wait_beats(5);
        @(negedge clk);
        num_frames = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num_frames = 16'd0;
        wait_done();
        chk("fc_three", frame_count, 32'd3);

        // 5: reset mid-scan, then a clean restart.
        ready_mode = 0;
        begin_scan(16'd2, 2);
        wait_beats(5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("rst_outputs", {col_addr[7:0], row_addr[7:0], m_data, m_valid, m_sof, m_eol, m_eof, busy, done},
            32'd0);
        chk("rst_frame_count", frame_count, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        begin_scan(16'd1, 1);
        wait_done();
        chk("fc_after_rst", frame_count, 32'd1);

        // 6: stop while the first beat is held by m_ready low.
        ready_mode = 2;
        begin_scan(16'd0, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (10) @(negedge clk);
        #3;
        chk("held_beat0", {m_valid, m_sof, m_data}, {29'd0, 1'b1, 1'b1, mem[0]});
        ready_mode = 1;
        wait_done();
        chk("fc_held_stop", frame_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
